mux_out_filter: RTL
===================

# mux_out_filter

Synchronous glitch filter and edge qualifier that sits directly downstream of the gate-level 2:1 mux. It consumes the mux `out` net, which is asynchronous and hazard-prone because of unequal gate rise and fall delays. The block synchronises that net, accepts a level change only after it has been stable for a programmable number of clocks, and reports qualified edges plus a running toggle count to the rest of the design.

## Interface
- `STABLE_CYCLES`, default 4: consecutive synchronised cycles a new level must hold before `dout` follows; legal range 1..16.
- `CNT_W`, default 8: width of the toggle counter.
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low; applies on its falling edge, released synchronously to `clk` by the system.
- `din`  input  1  raw mux output; asynchronous to `clk`.
- `en`  input  1  filter enable; when 0 the qualifier freezes.
- `clr`  input  1  synchronous clear of `toggle_cnt`.
- `dout`  output  1  filtered level (registered).
- `rise`  output  1  one-cycle pulse when `dout` goes 0->1.
- `fall`  output  1  one-cycle pulse when `dout` goes 1->0.
- `busy`  output  1  high while a candidate level change is being qualified.
- `toggle_cnt`  output  `CNT_W`  count of qualified edges; saturates at all-ones.

## Operation
- **Synchroniser.** Two flops, `din -> s1 -> s2`, reset to 0. They always run, independent of `en`.
- **FSM states:**
  - STABLE_LO: `dout`=0.
  - QUAL_HI: `dout`=0, candidate level 1.
  - STABLE_HI: `dout`=1.
  - QUAL_LO: `dout`=1, candidate level 0.
- **Qualify counter.** Internal 5-bit `qcnt`.
- **Transitions.** Evaluated only when `en`=1.
  - STABLE_x with `s2` != `dout`: go to QUAL_x and set `qcnt`=1.
  - QUAL_x with `s2` == `dout`: return to STABLE_x and set `qcnt`=0. The glitch is rejected; no pulse, no count.
  - QUAL_x with `s2` != `dout` and `qcnt` < `STABLE_CYCLES`-1: increment `qcnt`.
  - QUAL_x with `s2` != `dout` and `qcnt` == `STABLE_CYCLES`-1:
    - toggle `dout` and move to the opposite STABLE state;
    - set `qcnt`=0;
    - pulse `rise` or `fall` for one cycle;
    - increment `toggle_cnt`.
- **`STABLE_CYCLES`=1.** STABLE_x goes straight to the opposite STABLE state with the edge actions. QUAL states are never entered.
- **`en`=0.**
  - State, `qcnt` and `dout` hold.
  - `rise`/`fall` are 0.
  - `toggle_cnt` holds, except that `clr` still acts.
  - On re-enable, qualification resumes from the held `qcnt`.
- **`toggle_cnt` arithmetic.** Unsigned, `CNT_W` bits, saturating at 2^`CNT_W`-1 with no wrap.
- **`clr`.** Forces `toggle_cnt` to 0 on the next edge. If `clr` and a qualified edge coincide, `clr` wins and the result is 0. The `rise`/`fall` pulse and the `dout` change still occur.
- **`busy`.** Combinational decode: 1 in QUAL_HI and QUAL_LO, otherwise 0.

## Timing
- **Reset values.**
  - `s1`=`s2`=0, state STABLE_LO, `qcnt`=0.
  - `dout`=0, `rise`=`fall`=0, `busy`=0, `toggle_cnt`=0.
- **Reset mid-qualification.** Discards the pending change immediately (asynchronous).
- **Latency.** Let edge k be the first rising edge where `s1` captures a new `din` level that then stays stable:
  - `s2` updates at k+1;
  - the FSM first sees the difference at k+2;
  - `dout`, `rise`/`fall` and `toggle_cnt` update at edge k+1+`STABLE_CYCLES` (k+5 for the default).
- **Glitch rejection.** A `din` excursion visible on `s2` for fewer than `STABLE_CYCLES` consecutive cycles never reaches `dout`.
- **Pulse width.** `rise`/`fall` are registered and high for exactly one cycle. They are never both high.
- **Back-to-back edges.** Minimum spacing between two qualified edges is `STABLE_CYCLES` cycles.

## Test plan
- **Reset values.** Assert `rst_n`=0 mid-run with `din`=1 toggling -> all outputs 0 within the reset assertion, with no clock required. After release with `din`=0, outputs stay 0.
- **Clean rise.** Default params, `en`=1; `din` 0->1 and held; edge k is the first `s1` capture -> `dout`=1, `rise`=1 for one cycle and `toggle_cnt`=1 at edge k+5; `busy`=1 from k+2 through k+4.
- **Glitch rejection.** `din` high for 2 clocks then back to 0 -> `busy` pulses, `dout` stays 0, no `rise`, `toggle_cnt` unchanged. Then `din` low for 3 clocks while `dout`=1 -> `dout` stays 1.
- **Saturation and clear.** `CNT_W`=2; drive 5 qualified edges -> `toggle_cnt` reads 1,2,3,3,3. Assert `clr` in the same cycle as the 6th qualified edge -> `toggle_cnt`=0, `fall` still pulses and `dout` still toggles.
- **Enable freeze.**
  - Start a rise, then drop `en` at `qcnt`=2 for 10 cycles -> `dout`, `busy` and the count hold.
  - Re-assert `en` with `din` still 1 -> `dout`=1 two edges later.
- **Mux stimulus.** Drive `din` from the 2:1 mux, sweeping `a`/`b`/`sel` every 5 clocks with `STABLE_CYCLES`=1 and then 4 -> `dout` matches the ideal mux function, delayed, and no `rise`/`fall` pulses come from gate-delay hazards shorter than the filter window.

Source files
------------

// File: rtl/mux_out_filter.sv
// Glitch filter and edge qualifier for the asynchronous 2:1 mux output net.
// A new level reaches dout only after holding for STABLE_CYCLES synchronised clocks.
module mux_out_filter #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             en,
  input  logic             clr,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic [CNT_W-1:0] toggle_cnt
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    QUAL_HI   = 2'b01,
    STABLE_HI = 2'b11,
    QUAL_LO   = 2'b10
  } state_t;

  localparam logic [4:0]       QCNT_LAST = 5'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [1:0]       sync_reg;
  logic             s2;
  state_t           state_reg, state_next;
  logic [4:0]       qcnt_reg, qcnt_next;
  logic             dout_reg, dout_next;
  logic             rise_reg, rise_next;
  logic             fall_reg, fall_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             qual_edge;

  // Two-flop synchroniser; runs regardless of en so the pipeline never goes stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], din};
    end
  end

  assign s2 = sync_reg[1];

  always_comb begin
    state_next = state_reg;
    qcnt_next  = qcnt_reg;
    dout_next  = dout_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    qual_edge  = 1'b0;
    if (en) begin
      case (state_reg)
        STABLE_LO: begin
          if (s2) begin
            if (STABLE_CYCLES == 1) begin
              qual_edge = 1'b1;
            end else begin
              state_next = QUAL_HI;
              qcnt_next  = 5'd1;
            end
          end
        end
        QUAL_HI: begin
          if (!s2) begin
            state_next = STABLE_LO;
            qcnt_next  = 5'd0;
          end else if (qcnt_reg == QCNT_LAST) begin
            qual_edge = 1'b1;
          end else begin
            qcnt_next = qcnt_reg + 5'd1;
          end
        end
        STABLE_HI: begin
          if (!s2) begin
            if (STABLE_CYCLES == 1) begin
              qual_edge = 1'b1;
            end else begin
              state_next = QUAL_LO;
              qcnt_next  = 5'd1;
            end
          end
        end
        QUAL_LO: begin
          if (s2) begin
            state_next = STABLE_HI;
            qcnt_next  = 5'd0;
          end else if (qcnt_reg == QCNT_LAST) begin
            qual_edge = 1'b1;
          end else begin
            qcnt_next = qcnt_reg + 5'd1;
          end
        end
        default: begin
          state_next = STABLE_LO;
          qcnt_next  = 5'd0;
        end
      endcase
    end
    // A qualified edge always lands in the stable state opposite the current level.
    if (qual_edge) begin
      dout_next  = ~dout_reg;
      rise_next  = ~dout_reg;
      fall_next  = dout_reg;
      qcnt_next  = 5'd0;
      state_next = dout_reg ? STABLE_LO : STABLE_HI;
    end
  end

  // clr has priority over a coincident qualified edge; the counter never wraps.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (qual_edge && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= STABLE_LO;
      qcnt_reg  <= 5'd0;
      dout_reg  <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      qcnt_reg  <= qcnt_next;
      dout_reg  <= dout_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign dout       = dout_reg;
  assign rise       = rise_reg;
  assign fall       = fall_reg;
  assign busy       = (state_reg == QUAL_HI) || (state_reg == QUAL_LO);
  assign toggle_cnt = cnt_reg;

endmodule
